// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared state type, frame constants and parity helper for the PS/2 host transmitter
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    BITS,
    STOP,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam int PS2_DATA_BITS = 8;

  // Device clock falling-edge indices within a host-to-device frame
  localparam logic [3:0] PARITY_EDGE = 4'd9;
  localparam logic [3:0] STOP_EDGE   = 4'd10;
  localparam logic [3:0] ACK_EDGE    = 4'd11;

  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake and completion status of the PS/2 host transmitter
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic [PS2_DATA_BITS-1:0] tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     done;
  logic                     err;

  modport master (output tx_data, tx_valid, input tx_ready, done, err);
  modport slave  (input tx_data, tx_valid, output tx_ready, done, err);

endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop synchronizer for a raw PS/2 pin with registered falling-edge strobe
module ps2_line_sync (
  input  logic clk_core,
  input  logic core_reset_n,
  input  logic line_in,
  output logic line_sync,
  output logic fall
);

  logic meta;
  logic prev;

  // Idle PS/2 lines float high, so every stage resets to 1 to avoid a false edge
  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      meta      <= 1'b1;
      line_sync <= 1'b1;
      prev      <= 1'b1;
      fall      <= 1'b0;
    end else begin
      meta      <= line_in;
      line_sync <= meta;
      prev      <= line_sync;
      fall      <= prev & ~line_sync;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter (request-to-send, parity, stop, ACK)
// Optional watchdog from clock release to end of frame: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 4000,
  parameter int RTS_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 600000
) (
  input  logic         clk_core,
  input  logic         core_reset_n,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  // One cycle counter times inhibit and RTS, then serves as the watchdog once the clock is released
  localparam int CNT_MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(RTS_CYCLES - 1);

  ps2_state_t               state;
  logic [CNT_W-1:0]         cnt;
  logic [3:0]               edge_cnt;
  logic [PS2_DATA_BITS:0]   shreg;
  logic                     ack_err;
  logic                     clk_sync;
  logic                     clk_fall;
  logic                     data_sync;
  logic                     data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk_core     (clk_core),
    .core_reset_n (core_reset_n),
    .line_in      (ps2_clk_in),
    .line_sync    (clk_sync),
    .fall         (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk_core     (clk_core),
    .core_reset_n (core_reset_n),
    .line_in      (ps2_data_in),
    .line_sync    (data_sync),
    .fall         (data_fall_unused)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic watchdog_hit;
  assign watchdog_hit = (state inside {BITS, STOP, ACK, WAIT_IDLE}) && (cnt == TIMEOUT_LAST);
`endif

  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      edge_cnt    <= '0;
      shreg       <= '0;
      ack_err     <= 1'b0;
      tx.tx_ready <= 1'b1;
      tx.done     <= 1'b0;
      tx.err      <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
    end else begin
      tx.done <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      if (state inside {BITS, STOP, ACK, WAIT_IDLE}) cnt <= cnt + 1'b1;
      if (watchdog_hit) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        tx.done     <= 1'b1;
        tx.err      <= 1'b1;
        tx.tx_ready <= 1'b1;
        state       <= IDLE;
      end else begin
`else
      begin
`endif
        case (state)
          IDLE: begin
            if (tx.tx_valid) begin
              shreg       <= {odd_parity(tx.tx_data), tx.tx_data};
              cnt         <= '0;
              edge_cnt    <= '0;
              tx.tx_ready <= 1'b0;
              ps2_clk_oe  <= 1'b1;
              state       <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (cnt == INHIBIT_LAST) begin
              cnt         <= '0;
              ps2_data_oe <= 1'b1;
              state       <= RTS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RTS: begin
            if (cnt == RTS_LAST) begin
              cnt        <= '0;
              ps2_clk_oe <= 1'b0;
              state      <= BITS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BITS: begin
            if (clk_fall) begin
              ps2_data_oe <= ~shreg[0];
              shreg       <= {1'b0, shreg[PS2_DATA_BITS:1]};
              edge_cnt    <= edge_cnt + 1'b1;
              if (edge_cnt == PARITY_EDGE - 4'd1) state <= STOP;
            end
          end
          STOP: begin
            if (clk_fall) begin
              ps2_data_oe <= 1'b0;
              edge_cnt    <= STOP_EDGE;
              state       <= ACK;
            end
          end
          ACK: begin
            if (clk_fall) begin
              ack_err  <= data_sync;
              edge_cnt <= ACK_EDGE;
              state    <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
              tx.done     <= 1'b1;
              tx.err      <= ack_err;
              tx.tx_ready <= 1'b1;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a clocking/ACKing PS/2 device model
module tb_ps2_host_tx;

  localparam int HALF      = 20;
  localparam int TO_CYCLES = 3000;

  logic clk_core     = 1'b0;
  logic core_reset_n = 1'b0;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic ps2_clk_in;
  logic ps2_data_in;

  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;
  logic last_err    = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES (4000),
    .RTS_CYCLES     (16),
    .TIMEOUT_CYCLES (TO_CYCLES)
  ) dut (
    .clk_core     (clk_core),
    .core_reset_n (core_reset_n),
    .tx           (tx_if),
    .ps2_clk_in   (ps2_clk_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clk_oe   (ps2_clk_oe),
    .ps2_data_oe  (ps2_data_oe)
  );

  always #5 clk_core = ~clk_core;

  always @(negedge clk_core) begin
    if (tx_if.done === 1'b1) begin
      done_cnt++;
      last_err = tx_if.err;
    end
  end

  // Device side: waits for clock release, then clocks n_clk edges, sampling on each rising edge
  task automatic dev_frame(input int n_clk, input bit ack, output logic [10:0] bits, output bit ok);
    int t;
    bits = '0;
    ok   = 1'b1;
    t    = 0;
    while (ps2_clk_oe !== 1'b0 && t < 8000) begin
      @(negedge clk_core);
      t++;
    end
    if (ps2_clk_oe !== 1'b0) begin
      ok = 1'b0;
    end else begin
      repeat (HALF) @(negedge clk_core);
      bits[0] = ps2_data_in;
      for (int i = 1; i <= n_clk; i++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk_core);
        dev_clk_low = 1'b0;
        if (i <= 10) bits[i] = ps2_data_in;
        if (i == 10 && ack) begin
          repeat (4) @(negedge clk_core);
          dev_data_low = 1'b1;
        end
        repeat (HALF) @(negedge clk_core);
      end
      if (n_clk >= 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_core);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = b;
    @(negedge clk_core);
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    vectors++; if (tx_if.tx_ready !== 1'b1) begin miscompares++; $display("FAIL rst_tx_ready: got %b want 1", tx_if.tx_ready); end
    vectors++; if (tx_if.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", tx_if.done); end
    vectors++; if (tx_if.err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", tx_if.err); end
    vectors++; if (ps2_clk_oe !== 1'b0) begin miscompares++; $display("FAIL rst_clk_oe: got %b want 0", ps2_clk_oe); end
    vectors++; if (ps2_data_oe !== 1'b0) begin miscompares++; $display("FAIL rst_data_oe: got %b want 0", ps2_data_oe); end
    repeat (2) @(negedge clk_core);
    core_reset_n = 1'b1;
    repeat (3) @(negedge clk_core);
    vectors++; if (tx_if.tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin miscompares++; $display("FAIL post_rst_idle: got ready=%b clk_oe=%b want 1/0", tx_if.tx_ready, ps2_clk_oe); end
  endtask

  task automatic test_rts_timing();
    logic [10:0] bits;
    bit          ok;
    int          k;
    int          first_d;
    int          t;
    int          start_dc;
    start_dc = done_cnt;
    send_byte(8'hED);
    vectors++; if (ps2_clk_oe !== 1'b1 || tx_if.tx_ready !== 1'b0) begin miscompares++; $display("FAIL accept_latency: got clk_oe=%b ready=%b want 1/0", ps2_clk_oe, tx_if.tx_ready); end
    fork
      begin
        k = 0;
        first_d = -1;
        while (ps2_clk_oe === 1'b1 && k < 10000) begin
          if (ps2_data_oe === 1'b1 && first_d < 0) first_d = k;
          k++;
          @(negedge clk_core);
        end
      end
      dev_frame(11, 1'b1, bits, ok);
    join
    vectors++; if (k !== 4016) begin miscompares++; $display("FAIL clk_oe_high_time: got %0d want 4016", k); end
    vectors++; if (first_d !== 4000) begin miscompares++; $display("FAIL data_oe_rise: got %0d want 4000", first_d); end
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL rts_dev_ok: got %b want 1", ok); end
    vectors++; if (bits !== {1'b1, 1'b1, 8'hED, 1'b0}) begin miscompares++; $display("FAIL rts_bits: got %b want %b", bits, {1'b1, 1'b1, 8'hED, 1'b0}); end
    t = 0;
    while (done_cnt == start_dc && t < 2000) begin @(negedge clk_core); t++; end
    vectors++; if (done_cnt !== start_dc + 1 || last_err !== 1'b0) begin miscompares++; $display("FAIL rts_done: got count=%0d err=%b want %0d/0", done_cnt - start_dc, last_err, 1); end
  endtask

  task automatic test_send(input string tag, input logic [7:0] b, input bit ack,
                           input logic [10:0] exp_bits, input logic exp_err);
    logic [10:0] bits;
    bit          ok;
    int          t;
    int          start_dc;
    start_dc = done_cnt;
    send_byte(b);
    dev_frame(11, ack, bits, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL %s_dev_ok: got %b want 1", tag, ok); end
    vectors++; if (bits !== exp_bits) begin miscompares++; $display("FAIL %s_bits: got %b want %b", tag, bits, exp_bits); end
    t = 0;
    while (done_cnt == start_dc && t < 2000) begin @(negedge clk_core); t++; end
    vectors++; if (last_err !== exp_err) begin miscompares++; $display("FAIL %s_err: got %b want %b", tag, last_err, exp_err); end
    repeat (10) @(negedge clk_core);
    vectors++; if (done_cnt !== start_dc + 1) begin miscompares++; $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt - start_dc); end
    vectors++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_if.tx_ready !== 1'b1) begin miscompares++; $display("FAIL %s_released: got clk_oe=%b data_oe=%b ready=%b want 0/0/1", tag, ps2_clk_oe, ps2_data_oe, tx_if.tx_ready); end
  endtask

  task automatic test_parity();
    test_send("zero", 8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0);
    test_send("one",  8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b0);
  endtask

  task automatic test_nack();
    test_send("nack", 8'h55, 1'b0, {1'b1, 1'b1, 8'h55, 1'b0}, 1'b1);
  endtask

  task automatic test_reset_midframe();
    logic [10:0] bits;
    bit          ok;
    int          start_dc;
    start_dc = done_cnt;
    send_byte(8'h00);
    dev_frame(4, 1'b0, bits, ok);
    vectors++; if (ok !== 1'b1 || bits[4:0] !== 5'b00000) begin miscompares++; $display("FAIL mid_bits: got ok=%b bits=%b want 1/00000", ok, bits[4:0]); end
    vectors++; if (ps2_data_oe !== 1'b1) begin miscompares++; $display("FAIL mid_data_driven: got %b want 1", ps2_data_oe); end
    @(posedge clk_core);
    #2 core_reset_n = 1'b0;
    #1;
    vectors++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || tx_if.tx_ready !== 1'b1) begin miscompares++; $display("FAIL mid_async_reset: got clk_oe=%b data_oe=%b ready=%b want 0/0/1", ps2_clk_oe, ps2_data_oe, tx_if.tx_ready); end
    repeat (3) @(negedge clk_core);
    core_reset_n = 1'b1;
    repeat (5) @(negedge clk_core);
    vectors++; if (done_cnt !== start_dc) begin miscompares++; $display("FAIL mid_no_done: got %0d want 0", done_cnt - start_dc); end
    test_send("ff", 8'hFF, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0}, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits1;
    logic [10:0] bits2;
    bit          ok1;
    bit          ok2;
    int          t;
    int          start_dc;
    start_dc = done_cnt;
    send_byte(8'h01);
    fork
      dev_frame(11, 1'b1, bits1, ok1);
      begin
        t = 0;
        while (tx_if.done !== 1'b1 && t < 20000) begin @(negedge clk_core); t++; end
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'h5A;
        @(negedge clk_core);
        tx_if.tx_valid = 1'b0;
        vectors++; if (tx_if.tx_ready !== 1'b0 || ps2_clk_oe !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: got ready=%b clk_oe=%b want 0/1", tx_if.tx_ready, ps2_clk_oe); end
      end
    join
    vectors++; if (ok1 !== 1'b1 || bits1 !== {1'b1, 1'b0, 8'h01, 1'b0}) begin miscompares++; $display("FAIL b2b_first_bits: got %b want %b", bits1, {1'b1, 1'b0, 8'h01, 1'b0}); end
    dev_frame(11, 1'b1, bits2, ok2);
    vectors++; if (ok2 !== 1'b1 || bits2 !== {1'b1, 1'b1, 8'h5A, 1'b0}) begin miscompares++; $display("FAIL b2b_second_bits: got %b want %b", bits2, {1'b1, 1'b1, 8'h5A, 1'b0}); end
    t = 0;
    while (done_cnt < start_dc + 2 && t < 2000) begin @(negedge clk_core); t++; end
    repeat (5) @(negedge clk_core);
    vectors++; if (done_cnt !== start_dc + 2 || last_err !== 1'b0) begin miscompares++; $display("FAIL b2b_done: got count=%0d err=%b want 2/0", done_cnt - start_dc, last_err); end
  endtask

`ifdef PS2_TX_TIMEOUT_EN
  task automatic test_timeout();
    int t;
    int k;
    send_byte(8'hED);
    t = 0;
    while (ps2_clk_oe === 1'b1 && t < 8000) begin @(negedge clk_core); t++; end
    k = 0;
    while (tx_if.done !== 1'b1 && k < TO_CYCLES + 100) begin @(negedge clk_core); k++; end
    vectors++; if (k !== TO_CYCLES) begin miscompares++; $display("FAIL timeout_latency: got %0d want %0d", k, TO_CYCLES); end
    vectors++; if (tx_if.err !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin miscompares++; $display("FAIL timeout_state: got err=%b clk_oe=%b data_oe=%b want 1/0/0", tx_if.err, ps2_clk_oe, ps2_data_oe); end
    repeat (5) @(negedge clk_core);
  endtask
`endif

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    @(negedge clk_core);
    test_reset();
    test_rts_timing();
    test_send("ed", 8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0);
    test_parity();
    test_nack();
    test_reset_midframe();
    test_back_to_back();
`ifdef PS2_TX_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
